mdu: RTL and testbench

Multiply/divide unit for the five-stage MIPS core, sitting beside the ALU in stage E. It accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` from the E-stage control and models multi-cycle latency with a busy interval. It holds the architectural HI/LO registers, which feed `mfhi`/`mflo` results into the E→M pipeline register. The D-stage hazard logic stalls on `start | busy` for any MDU-class instruction.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_arith.sv | 71 +++++++
 rtl/mdu.sv | 109 ++++++++++
 tb/tb_mdu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit and the control units that issue to it.
// Divider support is selected with the MDU_DIV_EN macro in mdu_arith and mdu.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the MDU: maps md_op/rs/rt to a 64-bit {hi, lo} result.
// The divider only exists when MDU_DIV_EN is defined; otherwise DIV/DIVU report as no-ops.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  md_op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [63:0] result_o,
    output logic        long_op_o,
    output logic        div_op_o
);

    logic [63:0] sprod;
    logic [63:0] uprod;

    assign sprod = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    assign uprod = {32'b0, rs_i} * {32'b0, rt_i};

`ifdef MDU_DIV_EN
    logic        div_signed;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] den_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // One unsigned divider serves both forms; signed DIV runs on magnitudes and fixes signs after.
    assign div_signed = (md_op_i == MD_DIV);
    assign num        = (div_signed && rs_i[31]) ? (~rs_i + 32'd1) : rs_i;
    assign den        = (div_signed && rt_i[31]) ? (~rt_i + 32'd1) : rt_i;
    assign den_safe   = (den == 32'd0) ? 32'd1 : den;
    assign quo_mag    = num / den_safe;
    assign rem_mag    = num % den_safe;
    assign quo        = (div_signed && (rs_i[31] ^ rt_i[31])) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem        = (div_signed && rs_i[31]) ? (~rem_mag + 32'd1) : rem_mag;
`endif

    always_comb begin
        result_o  = '0;
        long_op_o = 1'b0;
        div_op_o  = 1'b0;
        case (md_op_i)
            MD_MULT: begin
                result_o  = sprod;
                long_op_o = 1'b1;
            end
            MD_MULTU: begin
                result_o  = uprod;
                long_op_o = 1'b1;
            end
`ifdef MDU_DIV_EN
            MD_DIV, MD_DIVU: begin
                long_op_o = 1'b1;
                div_op_o  = 1'b1;
                if (rt_i == 32'd0) begin
                    result_o = {rs_i, DIV_ZERO_LO};
                end else if (div_signed && rs_i == 32'h8000_0000 && rt_i == 32'hFFFF_FFFF) begin
                    result_o = {32'h0000_0000, 32'h8000_0000};
                end else begin
                    result_o = {rem, quo};
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// MDU top: accept FSM, latency counter, pending result and architectural HI/LO registers.
// Defining MDU_DIV_EN enables DIV/DIVU and sizes the counter for DIV_CYCLES.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MDU_DIV_EN
    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
`else
    localparam int MAX_CYCLES = MULT_CYCLES;
`endif
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      result;
    logic             long_op;
    logic             div_op;
    logic [CNT_W-1:0] cnt_load;

    mdu_arith u_arith (
        .md_op_i   (md_op),
        .rs_i      (rs),
        .rt_i      (rt),
        .result_o  (result),
        .long_op_o (long_op),
        .div_op_o  (div_op)
    );

    assign cnt_load = div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // start is only honoured in IDLE; anything arriving while BUSY is dropped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (long_op) begin
                        state_d   = ST_BUSY;
                        cnt_d     = cnt_load;
                        pend_hi_d = result[63:32];
                        pend_lo_d = result[31:0];
                    end else if (md_op == MD_MTHI) begin
                        hi_d = rs;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = rs;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed test-plan steps plus random ops against a 64-bit arithmetic model.
// The model follows MDU_DIV_EN the same way the design does.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs    = 32'd0;
    logic [31:0] rt    = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total      = 0;
    int bad        = 0;
    int violations = 0;

    logic [31:0] expHi = 32'd0;
    logic [31:0] expLo = 32'd0;

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // The control unit is supposed to stall instead of issuing while busy; count any such issue.
    always @(posedge clk) begin
        if (reset && start && busy) violations <= violations + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Architectural meaning of each op, using 64-bit host arithmetic.
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output bit isLong, output int cycles,
                           output logic [31:0] newHi, output logic [31:0] newLo);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        newHi  = expHi;
        newLo  = expLo;
        isLong = 1'b0;
        cycles = 0;
        case (op)
            3'd0: begin
                p = sa * sb;
                newHi = p[63:32]; newLo = p[31:0];
                isLong = 1'b1; cycles = MULT_N;
            end
            3'd1: begin
                up = ua * ub;
                newHi = up[63:32]; newLo = up[31:0];
                isLong = 1'b1; cycles = MULT_N;
            end
            3'd2, 3'd3: begin
                if (DIV_EN) begin
                    isLong = 1'b1; cycles = DIV_N;
                    if (b == 32'd0) begin
                        newLo = 32'hFFFF_FFFF; newHi = a;
                    end else if (op == 3'd2) begin
                        q = sa / sb; r = sa % sb;
                        newLo = q[31:0]; newHi = r[31:0];
                    end else begin
                        uq = ua / ub; ur = ua % ub;
                        newLo = uq[31:0]; newHi = ur[31:0];
                    end
                end
            end
            3'd4: newHi = a;
            3'd5: newLo = a;
            default: ;
        endcase
    endtask

    // Issue one op at the current negedge, then check busy and HI/LO each cycle until it is done.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        bit isLong;
        int cycles;
        logic [31:0] nh, nl;
        modelOp(op, a, b, isLong, cycles, nh, nl);
        start = 1'b1; md_op = op; rs = a; rt = b;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = 3'($urandom); rs = $urandom; rt = $urandom;
        if (isLong) begin
            for (int i = 0; i < cycles; i++) begin
                @(negedge clk);
                checkOutput($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, 32'd1);
                checkOutput($sformatf("%s hi hold[%0d]", tag, i), hi, expHi);
                checkOutput($sformatf("%s lo hold[%0d]", tag, i), lo, expLo);
            end
        end
        @(negedge clk);
        checkOutput($sformatf("%s busy done", tag), {31'd0, busy}, 32'd0);
        checkOutput($sformatf("%s hi", tag), hi, nh);
        checkOutput($sformatf("%s lo", tag), lo, nl);
        expHi = nh;
        expLo = nl;
    endtask

    initial begin
        bit isLong;
        int cycles;
        logic [31:0] nh, nl;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        $display("[TB] starting mdu test, DIV_EN=%0d", DIV_EN);

        // Reset values.
        #12;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // MULT -2 * 3, plus literal checks of the expected product.
        applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'd3, "mult -2*3");
        checkOutput("mult -2*3 hi literal", hi, 32'hFFFF_FFFF);
        checkOutput("mult -2*3 lo literal", lo, 32'hFFFF_FFFA);

        // Back-to-back issue in the cycle busy has just fallen.
        applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
        checkOutput("multu hi literal", hi, 32'hFFFF_FFFE);
        checkOutput("multu lo literal", lo, 32'h0000_0001);

        applyStimulus(MD_DIV,  32'hFFFF_FFF9, 32'd2,         "div -7/2");
        applyStimulus(MD_DIVU, 32'd5,         32'd0,         "divu by zero");
        applyStimulus(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        applyStimulus(MD_DIV,  32'd100,       32'd0,         "div by zero");
        applyStimulus(MD_DIV,  32'd7,         32'hFFFF_FFFE, "div 7/-2");
        applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0,         "mthi");
        applyStimulus(MD_MTLO, 32'h8765_4321, 32'd0,         "mtlo");
        applyStimulus(3'd6,    32'hDEAD_BEEF, 32'd1,         "reserved 6");
        applyStimulus(3'd7,    32'hCAFE_F00D, 32'd2,         "reserved 7");

        // MTLO issued while a MULT is in flight must be dropped.
        modelOp(MD_MULT, 32'd3, 32'd4, isLong, cycles, nh, nl);
        start = 1'b1; md_op = MD_MULT; rs = 32'd3; rt = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("viol busy[0]", {31'd0, busy}, 32'd1);
        start = 1'b1; md_op = MD_MTLO; rs = 32'hDEAD_BEEF;
        $display("[TB] note: injecting start while busy (protocol violation)");
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < cycles; i++) begin
            @(negedge clk);
            checkOutput($sformatf("viol busy[%0d]", i), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("viol lo hold[%0d]", i), lo, expLo);
        end
        @(negedge clk);
        checkOutput("viol busy done", {31'd0, busy}, 32'd0);
        checkOutput("viol hi", hi, nh);
        checkOutput("viol lo", lo, nl);
        checkOutput("viol flagged", 32'(violations), 32'd1);
        expHi = nh;
        expLo = nl;

        // Reset asserted on busy cycle 3 aborts the MULT with no late writeback.
        applyStimulus(MD_MTHI, 32'hA5A5_A5A5, 32'd0, "pre-abort mthi");
        start = 1'b1; md_op = MD_MULT; rs = 32'd7; rt = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort busy before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort hi", hi, 32'd0);
        checkOutput("abort lo", lo, 32'd0);
        expHi = 32'd0;
        expLo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post-abort busy[%0d]", i), {31'd0, busy}, 32'd0);
            checkOutput($sformatf("post-abort hi[%0d]", i), hi, 32'd0);
            checkOutput($sformatf("post-abort lo[%0d]", i), lo, 32'd0);
        end

        // Random ops, with a bias toward zero divisors and corner operands.
        for (int n = 0; n < 24; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            applyStimulus(rop, ra, rb, $sformatf("rand%0d op%0d", n, rop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
